// File: rtl/reg_file_sb.sv
// Multi-port integer register file with per-register busy scoreboard and a post-reset zeroing sweep.
// Optional same-cycle writeback-to-read bypass is enabled by defining RF_BYPASS_EN.
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipeline_en,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic [NWP-1:0]      wr_en,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic [NWP*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush_sb,
  output logic                ready
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   sweep_cnt;
  logic [AW-1:0]   sweep_cnt_nxt;
  logic            run;

  logic [XLEN-1:0] gpr [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic [AW-1:0]   wa [NWP];
  logic [XLEN-1:0] wd [NWP];
  logic [NWP-1:0]  wr_fire;
  logic [AW-1:0]   ra [NRP];
  logic            iss_fire;

  logic [XLEN-1:0] rd_word;
  logic            rd_bit;

  // ---------------------------------------------------------------
  // Sweep / run state machine
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    case (state)
      ST_INIT: begin
        sweep_cnt_nxt = sweep_cnt + 1'b1;
        if (sweep_cnt == AW'(NREG - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt     = ST_INIT;
        sweep_cnt_nxt = '0;
      end
    endcase
  end

  assign run   = (state == ST_RUN);
  assign ready = run;

  // ---------------------------------------------------------------
  // Port unpacking and qualified write / issue strobes
  // ---------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < NWP; p++) begin
      wa[p]      = wr_addr[p*AW +: AW];
      wd[p]      = wr_data[p*XLEN +: XLEN];
      wr_fire[p] = run & pipeline_en & wr_en[p] & (wr_addr[p*AW +: AW] != '0);
    end
  end

  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      ra[i] = rd_addr[i*AW +: AW];
    end
  end

  assign iss_fire = run & pipeline_en & iss_valid;

  // ---------------------------------------------------------------
  // Storage: no reset; later ports are applied last so they win collisions
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      gpr[sweep_cnt] <= '0;
    end else begin
      for (int p = 0; p < NWP; p++) begin
        if (wr_fire[p]) begin
          gpr[wa[p]] <= wd[p];
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Scoreboard: flush > issue > writeback clear > hold
  // ---------------------------------------------------------------
  always_comb begin
    busy_nxt = busy;
    if (flush_sb) begin
      busy_nxt = '0;
    end else begin
      for (int p = 0; p < NWP; p++) begin
        if (wr_fire[p]) begin
          busy_nxt[wa[p]] = 1'b0;
        end
      end
      if (iss_fire) begin
        busy_nxt[iss_rd] = 1'b1;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // ---------------------------------------------------------------
  // Combinational read ports
  // ---------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_word = '0;
    rd_bit  = 1'b0;
    for (int i = 0; i < NRP; i++) begin
      rd_word = gpr[ra[i]];
      rd_bit  = busy[ra[i]];
`ifdef RF_BYPASS_EN
      // A completing write is visible now; a same-cycle re-issue keeps it busy.
      for (int p = 0; p < NWP; p++) begin
        if (wr_fire[p] && (wa[p] == ra[i])) begin
          rd_word = wd[p];
          rd_bit  = iss_fire && (iss_rd == ra[i]);
        end
      end
`endif
      if (ra[i] == '0) begin
        rd_word = '0;
        rd_bit  = 1'b0;
      end
      rd_data[i*XLEN +: XLEN] = rd_word;
      rd_busy[i]              = rd_bit;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vector table, reset/sweep sequences, and randomized
// cycles checked against an array-based model of the register file and scoreboard.
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int AW   = 5;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                pipeline_en;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic [NWP-1:0]      wr_en;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush_sb;
  logic                ready;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
    .clk(clk), .rst(rst), .pipeline_en(pipeline_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush_sb(flush_sb),
    .ready(ready)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_gpr [NREG];
  bit              m_busy [NREG];
  int              m_swept;

  function automatic bit m_ready();
    return m_swept == NREG;
  endfunction

  function automatic void model_reset();
    m_swept = 0;
    for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
  endfunction

  function automatic bit wr_on(int p);
    return pipeline_en && wr_en[p] && (wr_addr[p*AW +: AW] != 0);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_edge();
    if (!m_ready()) begin
      if (flush_sb) for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      m_gpr[m_swept] = '0;
      m_swept++;
    end else begin
      for (int p = 0; p < NWP; p++) begin
        if (wr_on(p)) begin
          m_gpr[wr_addr[p*AW +: AW]]  = wr_data[p*XLEN +: XLEN];
          m_busy[wr_addr[p*AW +: AW]] = 1'b0;
        end
      end
      if (flush_sb) begin
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      end else if (pipeline_en && iss_valid && iss_rd != 0) begin
        m_busy[iss_rd] = 1'b1;
      end
    end
  endfunction

  function automatic logic [XLEN-1:0] exp_data(logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_gpr[a];
    if (BYP && m_ready())
      for (int p = 0; p < NWP; p++)
        if (wr_on(p) && wr_addr[p*AW +: AW] == a) v = wr_data[p*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic exp_busy(logic [AW-1:0] a);
    logic b;
    if (a == 0) return 1'b0;
    b = m_busy[a];
    if (BYP && m_ready())
      for (int p = 0; p < NWP; p++)
        if (wr_on(p) && wr_addr[p*AW +: AW] == a) b = pipeline_en && iss_valid && (iss_rd == a);
    return b;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    for (int i = 0; i < NRP; i++) begin
      chk($sformatf("%s rd_data[%0d]", tag, i), rd_data[i*XLEN +: XLEN], exp_data(rd_addr[i*AW +: AW]));
      chk($sformatf("%s rd_busy[%0d]", tag, i), XLEN'(rd_busy[i]), XLEN'(exp_busy(rd_addr[i*AW +: AW])));
    end
    chk($sformatf("%s ready", tag), XLEN'(ready), XLEN'(m_ready()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    pipeline_en = 1'b1;
    wr_en       = '0;
    wr_addr     = '0;
    wr_data     = '0;
    iss_valid   = 1'b0;
    iss_rd      = '0;
    flush_sb    = 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Full sweep from reset release: ready low for cycles 0..31, high by cycle 33, all zero after.
  task automatic sweep_check(input string tag);
    for (int k = 0; k < NREG; k++) begin
      chk($sformatf("%s ready_c%0d", tag, k), XLEN'(ready), '0);
      tick();
    end
    tick();
    chk($sformatf("%s ready_c33", tag), XLEN'(ready), XLEN'(1));
    for (int a = 0; a < NREG; a++) begin
      set_rd(AW'(a), AW'(NREG - 1 - a));
      #1;
      chk($sformatf("%s zero r%0d", tag, a), rd_data[XLEN-1:0], '0);
      chk($sformatf("%s zero r%0d", tag, NREG - 1 - a), rd_data[2*XLEN-1:XLEN], '0);
      chk($sformatf("%s busy r%0d", tag, a), XLEN'(rd_busy), '0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit              pe;
    logic [1:0]      we;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    bit              iv;
    logic [AW-1:0]   ir;
    bit              fl;
    logic [AW-1:0]   ra0, ra1;
    logic [XLEN-1:0] d0, d1;
    bit              b0, b1;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit pe, logic [1:0] we, logic [AW-1:0] wa0, logic [XLEN-1:0] wd0,
                              logic [AW-1:0] wa1, logic [XLEN-1:0] wd1, bit iv, logic [AW-1:0] ir,
                              bit fl, logic [AW-1:0] ra0, logic [AW-1:0] ra1,
                              logic [XLEN-1:0] d0, logic [XLEN-1:0] d1, bit b0, bit b1);
    vec_t v;
    v.pe = pe; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iv = iv; v.ir = ir; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
    v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle();
    model_reset();

    // Table rows: inputs for one cycle, outputs observed during that cycle (before its edge).
    add(1, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5,
        BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    add(1, 2'b01, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 1, 7, 0, 7, 7, 32'h0, 32'h0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h0, 32'h0, 1, 1);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h0, 32'h0, 1, 1);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h0, 32'h0, 1, 1);
    add(1, 2'b01, 7, 32'h55, 0, 0, 0, 0, 0, 7, 7,
        BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0, !BYP, !BYP);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h55, 32'h55, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 1, 7, 0, 7, 7, 32'h55, 32'h55, 0, 0);
    add(0, 2'b01, 7, 32'h99, 0, 0, 0, 0, 0, 7, 7, 32'h55, 32'h55, 1, 1);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h55, 32'h55, 1, 1);
    add(1, 2'b01, 9, 32'h11, 0, 0, 1, 9, 0, 5, 7, 32'hDEADBEEF, 32'h55, 0, 1);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h11, 32'h11, 1, 1);
    add(1, 2'b00, 0, 0, 0, 0, 1, 9, 1, 9, 9, 32'h11, 32'h11, 1, 1);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 7, 32'h11, 32'h55, 0, 0);
    add(1, 2'b11, 3, 32'hAAAA, 3, 32'hBBBB, 0, 0, 0, 3, 3,
        BYP ? 32'hBBBB : 32'h0, BYP ? 32'hBBBB : 32'h0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 3, 32'hBBBB, 32'hBBBB, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 1, 4, 0, 4, 4, 32'h0, 32'h0, 0, 0);
    add(1, 2'b01, 4, 32'h77, 0, 0, 0, 0, 0, 4, 4,
        BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, !BYP, !BYP);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4, 4, 32'h77, 32'h77, 0, 0);
    add(0, 2'b00, 0, 0, 0, 0, 1, 10, 0, 10, 10, 32'h0, 32'h0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 10, 10, 32'h0, 32'h0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 1, 6, 0, 6, 6, 32'h0, 32'h0, 0, 0);
    add(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 6, 6, 32'h0, 32'h0, 1, 1);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 6, 6, 32'h0, 32'h0, 0, 0);
    add(1, 2'b10, 0, 0, 8, 32'hCAFE, 0, 0, 0, 8, 8,
        BYP ? 32'hCAFE : 32'h0, BYP ? 32'hCAFE : 32'h0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 8, 8, 32'hCAFE, 32'hCAFE, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    set_rd(1, 0);
    #1;
    chk("reset ready", XLEN'(ready), '0);
    chk("reset rd_busy", XLEN'(rd_busy), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    sweep_check("init");

    // Directed table
    foreach (tbl[i]) begin
      pipeline_en = tbl[i].pe;
      wr_en       = tbl[i].we;
      wr_addr     = {tbl[i].wa1, tbl[i].wa0};
      wr_data     = {tbl[i].wd1, tbl[i].wd0};
      iss_valid   = tbl[i].iv;
      iss_rd      = tbl[i].ir;
      flush_sb    = tbl[i].fl;
      set_rd(tbl[i].ra0, tbl[i].ra1);
      #1;
      chk($sformatf("tbl%0d d0", i), rd_data[XLEN-1:0], tbl[i].d0);
      chk($sformatf("tbl%0d d1", i), rd_data[2*XLEN-1:XLEN], tbl[i].d1);
      chk($sformatf("tbl%0d b0", i), XLEN'(rd_busy[0]), XLEN'(tbl[i].b0));
      chk($sformatf("tbl%0d b1", i), XLEN'(rd_busy[1]), XLEN'(tbl[i].b1));
      chk($sformatf("tbl%0d ready", i), XLEN'(ready), XLEN'(1));
      tick();
    end
    idle();

    // Reset in RUN clears busy bits immediately
    iss_valid = 1'b1;
    iss_rd    = 12;
    tick();
    idle();
    set_rd(12, 12);
    #1;
    chk("run busy r12 before rst", XLEN'(rd_busy[0]), XLEN'(1));
    rst = 1'b1;
    model_reset();
    #1;
    chk("run rst ready", XLEN'(ready), '0);
    chk("run rst busy r12", XLEN'(rd_busy[0]), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset at sweep count 10: the sweep must restart in full
    repeat (10) tick();
    chk("sweep10 ready", XLEN'(ready), '0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("sweep10 rst ready", XLEN'(ready), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sweep_check("resweep");

    // Randomized cycles against the model
    for (int c = 0; c < 600; c++) begin
      pipeline_en = ($urandom_range(0, 9) != 0);
      wr_en       = NWP'($urandom_range(0, 3));
      for (int p = 0; p < NWP; p++) begin
        wr_addr[p*AW +: AW]   = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
        wr_data[p*XLEN +: XLEN] = $urandom;
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
      flush_sb  = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NRP; i++) begin
        if ($urandom_range(0, 3) == 0)
          rd_addr[i*AW +: AW] = wr_addr[($urandom_range(0, NWP - 1))*AW +: AW];
        else
          rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      end
      #1;
      chk_model($sformatf("rnd%0d", c));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
